mc_ctrl_fsm: RTL and testbench

Multicycle ARM control unit, the upstream end of the conditional-execution interface. It is a Moore main FSM plus an ALU/flag decoder. It produces the raw, unconditioned PCS, RegW, MemW and FlagW requests that the condition logic gates with CondEx, along with the datapath mux selects, IRWrite and NextPC. Instruction fields (Op, Funct, Rd) come from the instruction register; they are stable from the cycle after FETCH.

---
 rtl/mc_ctrl_fsm.sv | 191 +++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multicycle ARM control unit: Moore main FSM with registered outputs plus ALU/flag decode.
// Optional build macro MCFSM_CMP_NOWB_EN: CMP returns to FETCH straight after execute, skipping ALUWB.
module mc_ctrl_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         Op,
  input  logic [5:0]         Funct,
  input  logic [3:0]         Rd,
  output logic               IRWrite,
  output logic               NextPC,
  output logic               AdrSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUControl,
  output logic               PCS,
  output logic               RegW,
  output logic               MemW,
  output logic [1:0]         FlagW,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  typedef struct packed {
    logic       ir_write;
    logic       next_pc;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_control;
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic [1:0] flag_w;
  } ctl_t;

  state_t state_q;
  state_t state_d;
  ctl_t   ctl_q;
  ctl_t   ctl_d;

  // Control word for a given state; instruction fields are stable whenever they matter
  function automatic ctl_t decode_ctl(input state_t s, input logic [5:0] funct,
                                      input logic [3:0] rd);
    ctl_t c;
    logic alu_op;
    logic branch;
    c      = '0;
    alu_op = 1'b0;
    branch = 1'b0;
    case (s)
      FETCH: begin
        c.ir_write   = 1'b1;
        c.next_pc    = 1'b1;
        c.alu_src_a  = 2'b01;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      DECODE: begin
        c.alu_src_a  = 2'b01;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      MEMADR:   c.alu_src_b = 2'b01;
      MEMREAD:  c.adr_src = 1'b1;
      MEMWB: begin
        c.result_src = 2'b01;
        c.reg_w      = 1'b1;
      end
      MEMWRITE: begin
        c.adr_src = 1'b1;
        c.mem_w   = 1'b1;
      end
      EXECUTER: alu_op = 1'b1;
      EXECUTEI: begin
        c.alu_src_b = 2'b01;
        alu_op      = 1'b1;
      end
      ALUWB:    c.reg_w = 1'b1;
      BRANCH: begin
        c.alu_src_a  = 2'b10;
        c.alu_src_b  = 2'b01;
        c.result_src = 2'b10;
        branch       = 1'b1;
      end
      default: ;
    endcase

    // Unrecognised commands leave both ALU control and flag writes at zero
    if (alu_op) begin
      case (funct[4:1])
        4'b0100: begin
          c.alu_control = 2'b00;
          c.flag_w      = {funct[0], funct[0]};
        end
        4'b0010, 4'b1010: begin
          c.alu_control = 2'b01;
          c.flag_w      = {funct[0], funct[0]};
        end
        4'b0000: begin
          c.alu_control = 2'b10;
          c.flag_w      = {funct[0], 1'b0};
        end
        4'b1100: begin
          c.alu_control = 2'b11;
          c.flag_w      = {funct[0], 1'b0};
        end
        default: begin
          c.alu_control = 2'b00;
          c.flag_w      = 2'b00;
        end
      endcase
    end

    c.pcs = branch | c.next_pc | (c.reg_w & (rd == 4'hF));
    return c;
  endfunction

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (Op)
          2'b00:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: state_d = FETCH;
      EXECUTER, EXECUTEI: begin
`ifdef MCFSM_CMP_NOWB_EN
        state_d = (Funct[4:1] == 4'b1010) ? FETCH : ALUWB;
`else
        state_d = ALUWB;
`endif
      end
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
      default:  state_d = FETCH;
    endcase
  end

  always_comb begin
    ctl_d = decode_ctl(state_d, Funct, Rd);
  end

  // Outputs are registered alongside the state so they always describe the current state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      ctl_q   <= decode_ctl(FETCH, 6'd0, 4'd0);
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
    end
  end

  assign IRWrite    = ctl_q.ir_write;
  assign NextPC     = ctl_q.next_pc;
  assign AdrSrc     = ctl_q.adr_src;
  assign ALUSrcA    = ctl_q.alu_src_a;
  assign ALUSrcB    = ctl_q.alu_src_b;
  assign ResultSrc  = ctl_q.result_src;
  assign ALUControl = ctl_q.alu_control;
  assign PCS        = ctl_q.pcs;
  assign RegW       = ctl_q.reg_w;
  assign MemW       = ctl_q.mem_w;
  assign FlagW      = ctl_q.flag_w;
  assign state      = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized self-checking bench for mc_ctrl_fsm: each instruction's expected state walk and
// control outputs are derived from its class (DP, LDR, STR, B, illegal) and the decoder rules.
module tb_mc_ctrl_fsm;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4;
  localparam int S_MEMWRITE = 5, S_EXECR = 6, S_EXECI = 7, S_ALUWB = 8, S_BRANCH = 9;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] Op = '0;
  logic [5:0] Funct = '0;
  logic [3:0] Rd = '0;
  logic       IRWrite, NextPC, AdrSrc, PCS, RegW, MemW;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUControl, FlagW;
  logic [3:0] state;
  logic [15:0] obs_ctl;

  int tests_run = 0;
  int tests_failed = 0;

  mc_ctrl_fsm #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Rd(Rd),
    .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ALUControl(ALUControl), .PCS(PCS), .RegW(RegW), .MemW(MemW),
    .FlagW(FlagW), .state(state)
  );

  always #5 clk = ~clk;

  assign obs_ctl = {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                    ALUControl, PCS, RegW, MemW, FlagW};

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Expected control word for one cycle of an instruction, straight from the output table
  function automatic logic [15:0] expected_ctl(input int st, input logic [5:0] funct,
                                               input logic [3:0] rd);
    logic ir, npc, adr, pcs, regw, memw;
    logic [1:0] srca, srcb, res, aluc, flagw;
    ir = 0; npc = 0; adr = 0; pcs = 0; regw = 0; memw = 0;
    srca = 0; srcb = 0; res = 0; aluc = 0; flagw = 0;
    case (st)
      S_FETCH:    begin ir = 1; npc = 1; srca = 1; srcb = 2; res = 2; pcs = 1; end
      S_DECODE:   begin srca = 1; srcb = 2; res = 2; end
      S_MEMADR:   srcb = 1;
      S_MEMREAD:  adr = 1;
      S_MEMWB:    begin res = 1; regw = 1; pcs = (rd == 4'hF); end
      S_MEMWRITE: begin adr = 1; memw = 1; end
      S_EXECR, S_EXECI: begin
        if (st == S_EXECI) srcb = 1;
        case (funct[4:1])
          4'b0100: begin aluc = 0; flagw = {funct[0], funct[0]}; end
          4'b0010: begin aluc = 1; flagw = {funct[0], funct[0]}; end
          4'b1010: begin aluc = 1; flagw = {funct[0], funct[0]}; end
          4'b0000: begin aluc = 2; flagw = {funct[0], 1'b0}; end
          4'b1100: begin aluc = 3; flagw = {funct[0], 1'b0}; end
          default: ;
        endcase
      end
      S_ALUWB:    begin regw = 1; pcs = (rd == 4'hF); end
      S_BRANCH:   begin srca = 2; srcb = 1; res = 2; pcs = 1; end
      default: ;
    endcase
    return {ir, npc, adr, srca, srcb, res, aluc, pcs, regw, memw, flagw};
  endfunction

  // Called while in FETCH just after an edge; walks the whole instruction back to FETCH
  task automatic applyStimulus(input logic [1:0] op, input logic [5:0] funct,
                               input logic [3:0] rd);
    int path[$];
    Op = op; Funct = funct; Rd = rd;
    path = {S_FETCH, S_DECODE};
    case (op)
      2'b00: begin
        path.push_back(funct[5] ? S_EXECI : S_EXECR);
`ifdef MCFSM_CMP_NOWB_EN
        if (funct[4:1] != 4'b1010) path.push_back(S_ALUWB);
`else
        path.push_back(S_ALUWB);
`endif
      end
      2'b01: begin
        path.push_back(S_MEMADR);
        if (funct[0]) begin
          path.push_back(S_MEMREAD);
          path.push_back(S_MEMWB);
        end else begin
          path.push_back(S_MEMWRITE);
        end
      end
      2'b10: path.push_back(S_BRANCH);
      default: ;
    endcase
    foreach (path[i]) begin
      checkOutput($sformatf("state op=%0d f=%02h rd=%0d step%0d", op, funct, rd, i),
                  32'(state), 32'(path[i]));
      checkOutput($sformatf("ctl op=%0d f=%02h rd=%0d step%0d", op, funct, rd, i),
                  32'(obs_ctl), 32'(expected_ctl(path[i], funct, rd)));
      @(posedge clk); #1;
    end
    checkOutput($sformatf("return op=%0d f=%02h", op, funct), 32'(state), 32'(S_FETCH));
  endtask

  initial begin
    logic [3:0] cmds [5];
    logic [3:0] cmd;
    logic [5:0] funct;
    cmds = '{4'b0100, 4'b0010, 4'b1010, 4'b0000, 4'b1100};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset state", 32'(state), 32'(S_FETCH));
    checkOutput("reset ctl", 32'(obs_ctl), 32'(expected_ctl(S_FETCH, 6'd0, 4'd0)));
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("release state", 32'(state), 32'(S_FETCH));

    applyStimulus(2'b00, 6'b001001, 4'd1);
    applyStimulus(2'b00, 6'b101001, 4'd1);
    applyStimulus(2'b00, 6'b011000, 4'd2);
    applyStimulus(2'b01, 6'b000001, 4'd15);
    applyStimulus(2'b01, 6'b000000, 4'd4);
    applyStimulus(2'b10, 6'b000000, 4'd0);
    applyStimulus(2'b11, 6'b111111, 4'd15);
    applyStimulus(2'b00, 6'b010101, 4'd0);
    applyStimulus(2'b00, 6'b010101, 4'd15);
    applyStimulus(2'b00, 6'b000111, 4'd15);

    // Reset landing in the middle of a store must kill MemW asynchronously
    Op = 2'b01; Funct = 6'b000000; Rd = 4'd3;
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("pre-reset state", 32'(state), 32'(S_MEMWRITE));
    checkOutput("pre-reset MemW", 32'(MemW), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("async reset MemW", 32'(MemW), 32'd0);
    checkOutput("async reset state", 32'(state), 32'(S_FETCH));
    checkOutput("async reset ctl", 32'(obs_ctl), 32'(expected_ctl(S_FETCH, 6'd0, 4'd0)));
    @(negedge clk);
    @(negedge clk);
    checkOutput("held reset state", 32'(state), 32'(S_FETCH));
    rst = 1'b1;
    #1;

    for (int n = 0; n < 300; n++) begin
      cmd = cmds[$urandom_range(0, 4)];
      if ($urandom_range(0, 1) == 1)
        funct = {1'($urandom), cmd, 1'($urandom)};
      else
        funct = 6'($urandom);
      applyStimulus(2'($urandom), funct,
                    ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
